time_seg_595: RTL

Display back-end for the digital clock: takes the binary `hours`/`minutes`/`seconds` values and the one-hot digit select `sel_gen` from the time-generation stage, and converts the active digit to a common-anode 7-segment code. It serialises `{seg, sel}` into a 74HC595 shift-register chain on every digit change. It sits directly downstream of the time generator and drives the board's 595 pins.

---
 rtl/time_seg_595.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/time_seg_595.sv
// time_seg_595: display back-end for the digital clock.
// Converts the digit selected by sel_gen into a common-anode 7-segment code
// and shifts {seg, sel} into a 74HC595 chain each time the selected digit
// changes. The word goes out LSB first, then stcp latches it.
// Optional feature: define TIME_SEG_DP_EN to light the decimal point on the
// hours-ones and minutes-ones digits, so the display reads hh.mm.ss.
module time_seg_595 #(
  parameter int unsigned SHIFT_HALF = 2  // shcp half-period in clk cycles, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic [5:0] sel_gen,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       oe_n
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_e;

  localparam logic [7:0] HALF_LAST = 8'(SHIFT_HALF - 1);
  localparam logic [3:0] LAST_BIT  = 4'd13;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}.
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_of(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'hC0;
      4'd1:    code = 8'hF9;
      4'd2:    code = 8'hA4;
      4'd3:    code = 8'hB0;
      4'd4:    code = 8'h99;
      4'd5:    code = 8'h92;
      4'd6:    code = 8'h82;
      4'd7:    code = 8'hF8;
      4'd8:    code = 8'h80;
      4'd9:    code = 8'h90;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  state_e      state_q, state_d;
  logic [13:0] frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;     // 0: shcp low half, 1: shcp high half
  logic [7:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic [5:0]  sel_prev_q, sel_prev_d;  // sel_gen delayed by one cycle
  logic        first_q, first_d;     // forces a frame right after reset
  logic        oe_n_q, oe_n_d;
  logic        ds_q, ds_d;
  logic        shcp_q, shcp_d;
  logic        stcp_q, stcp_d;

  logic        change;
  logic [7:0]  digit_val;
  logic        use_tens;
  logic        sel_valid;
  logic        dp_digit;
  logic [7:0]  tens;
  logic [7:0]  ones;
  logic [3:0]  digit;
  logic [7:0]  seg_code;
  logic [5:0]  sel_out;
  logic [13:0] frame_word;
  logic [3:0]  bit_next;

  // Pick the value and tens/ones half addressed by the one-hot select.
  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    digit_val = 8'd0;
    use_tens  = 1'b0;
    sel_valid = 1'b1;
    dp_digit  = 1'b0;
    case (sel_gen)
      6'b000001: digit_val = seconds;
      6'b000010: begin digit_val = seconds; use_tens = 1'b1; end
      6'b000100: begin digit_val = minutes; dp_digit = 1'b1; end
      6'b001000: begin digit_val = minutes; use_tens = 1'b1; end
      6'b010000: begin digit_val = hours;   dp_digit = 1'b1; end
      6'b100000: begin digit_val = hours;   use_tens = 1'b1; end
      default:   sel_valid = 1'b0;  // zero or more than one bit set
    endcase
  end

  // BCD split and segment encoding of the active digit; builds the frame.
  always_comb begin
    tens     = digit_val / 8'd10;
    ones     = digit_val % 8'd10;
    digit    = use_tens ? tens[3:0] : ones[3:0];
    seg_code = SEG_BLANK;
    sel_out  = 6'b000000;
    if (sel_valid) begin
      sel_out = sel_gen;
      if (digit_val >= 8'd100) begin
        seg_code = SEG_DASH;
      end else begin
        seg_code = seg_of(digit);
`ifdef TIME_SEG_DP_EN
        if (dp_digit) seg_code[7] = 1'b0;
`endif
      end
    end
    frame_word = {seg_code, sel_out};
  end

  // Next-state and registered-output logic for the 595 transfer FSM.
  always_comb begin
    change     = first_q || (sel_gen != sel_prev_q);
    bit_next   = bit_q + 4'd1;
    state_d    = state_q;
    frame_d    = frame_q;
    bit_d      = bit_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    sel_prev_d = sel_gen;
    first_d    = 1'b0;
    oe_n_d     = oe_n_q;
    ds_d       = ds_q;
    shcp_d     = shcp_q;
    stcp_d     = stcp_q;
    case (state_q)
      ST_IDLE: begin
        if (change) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Snapshot the inputs; a change in this very cycle still re-arms.
        frame_d   = frame_word;
        pending_d = change;
        bit_d     = 4'd0;
        phase_d   = 1'b0;
        cnt_d     = 8'd0;
        ds_d      = frame_word[0];
        shcp_d    = 1'b0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (change) pending_d = 1'b1;
        if (cnt_q == HALF_LAST) begin
          cnt_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
            shcp_d  = 1'b1;       // rising edge mid-bit, ds already stable
          end else if (bit_q == LAST_BIT) begin
            shcp_d  = 1'b0;
            stcp_d  = 1'b1;
            state_d = ST_LATCH;
          end else begin
            bit_d   = bit_next;
            phase_d = 1'b0;
            shcp_d  = 1'b0;
            ds_d    = frame_q[bit_next];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_LATCH: begin
        if (change) pending_d = 1'b1;
        if (cnt_q == HALF_LAST) begin
          cnt_d   = 8'd0;
          stcp_d  = 1'b0;
          oe_n_d  = 1'b0;         // 595 now holds a valid pattern
          state_d = (pending_q || change) ? ST_LOAD : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= 14'd0;
      bit_q      <= 4'd0;
      phase_q    <= 1'b0;
      cnt_q      <= 8'd0;
      pending_q  <= 1'b0;
      sel_prev_q <= 6'd0;
      first_q    <= 1'b1;
      oe_n_q     <= 1'b1;
      ds_q       <= 1'b0;
      shcp_q     <= 1'b0;
      stcp_q     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this clock edge.
      state_q    <= state_d;
      frame_q    <= frame_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      sel_prev_q <= sel_prev_d;
      first_q    <= first_d;
      oe_n_q     <= oe_n_d;
      ds_q       <= ds_d;
      shcp_q     <= shcp_d;
      stcp_q     <= stcp_d;
    end
  end

  assign ds   = ds_q;
  assign shcp = shcp_q;
  assign stcp = stcp_q;
  assign oe_n = oe_n_q;

endmodule
